// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: memory-wait freeze, branch
// redirect (including one deferred across a freeze), load-use stall, perf counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int PC_W     = 64,
    parameter int CNT_W    = 32,
    parameter int WDOG_MAX = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic [PC_W-1:0]   ex_target,
    input  logic              mem_busy,
    input  logic              cnt_clr,
    output logic              pc_stall,
    output logic              ifid_hazard,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_freeze,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count,
    output logic              timeout_err
);

    localparam int FC_W = ($clog2(WDOG_MAX + 1) > 8) ? $clog2(WDOG_MAX + 1) : 8;
    localparam logic [FC_W-1:0] WDOG_LIM = FC_W'(WDOG_MAX);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        PEND   = 2'd2
    } state_t;

    state_t            st_q, st_d;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic [FC_W-1:0]   freeze_cnt_q, freeze_cnt_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              timeout_q, timeout_d;
    logic              lu;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [FC_W-1:0] wdog_sat_inc(input logic [FC_W-1:0] v);
        return (v >= WDOG_LIM) ? WDOG_LIM : v + 1'b1;
    endfunction

    // x0 is hardwired to zero, so a load targeting it can never create a dependency
    assign lu = ex_mem_read && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        pc_stall       = 1'b0;
        ifid_hazard    = 1'b0;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        pipe_freeze    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (mem_busy) begin
            pc_stall    = 1'b1;
            ifid_hazard = 1'b1;
            pipe_freeze = 1'b1;
        end else if (st_q == PEND) begin
            // the branch still in EX is the one already captured; use the saved target
            redirect_valid = 1'b1;
            redirect_pc    = pend_pc_q;
            ifid_flush     = 1'b1;
            idex_bubble    = 1'b1;
        end else if (ex_branch_taken) begin
            redirect_valid = 1'b1;
            redirect_pc    = ex_target;
            ifid_flush     = 1'b1;
            idex_bubble    = 1'b1;
        end else if (lu) begin
            pc_stall    = 1'b1;
            ifid_hazard = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        st_d      = st_q;
        pend_pc_d = pend_pc_q;
        case (st_q)
            RUN: begin
                if (mem_busy && ex_branch_taken) begin
                    st_d      = PEND;
                    pend_pc_d = ex_target;
                end else if (mem_busy) begin
                    st_d = FREEZE;
                end
            end
            FREEZE: begin
                if (!mem_busy) begin
                    st_d = RUN;
                end else if (ex_branch_taken) begin
                    st_d      = PEND;
                    pend_pc_d = ex_target;
                end
            end
            PEND: begin
                if (!mem_busy) begin
                    st_d = RUN;
                end
            end
            default: st_d = RUN;
        endcase
    end

    always_comb begin
        freeze_cnt_d = mem_busy ? wdog_sat_inc(freeze_cnt_q) : '0;
        if (cnt_clr) begin
            stall_d   = '0;
            flush_d   = '0;
            timeout_d = 1'b0;
        end else begin
            stall_d   = pc_stall ? cnt_sat_inc(stall_q) : stall_q;
            flush_d   = redirect_valid ? cnt_sat_inc(flush_q) : flush_q;
            timeout_d = timeout_q || (freeze_cnt_d == WDOG_LIM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q         <= RUN;
            pend_pc_q    <= '0;
            freeze_cnt_q <= '0;
            stall_q      <= '0;
            flush_q      <= '0;
            timeout_q    <= 1'b0;
        end else begin
            st_q         <= st_d;
            pend_pc_q    <= pend_pc_d;
            freeze_cnt_q <= freeze_cnt_d;
            stall_q      <= stall_d;
            flush_q      <= flush_d;
            timeout_q    <= timeout_d;
        end
    end

    assign state        = st_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
    assign timeout_err  = timeout_q;

endmodule
